// File: rtl/id_ex_stage.sv
// ============================================================================
// Module   : id_ex_stage
// Brief    : Decode-to-execute pipeline register with valid/ready handshake
//            and a two-entry (main + skid) buffer. Optional stall counter
//            enabled by defining IDEX_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module id_ex_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4,
    parameter int CTRL_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_pc,
    input  logic [DATA_W-1:0]     in_rd1,
    input  logic [DATA_W-1:0]     in_rd2,
    input  logic [DATA_W-1:0]     in_imm,
    input  logic [REG_ADDR_W-1:0] in_rd_addr,
    input  logic [CTRL_W-1:0]     in_ctrl,
`ifdef IDEX_STATS_EN
    output logic [31:0]           stall_cycles,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_pc,
    output logic [DATA_W-1:0]     out_rd1,
    output logic [DATA_W-1:0]     out_rd2,
    output logic [DATA_W-1:0]     out_imm,
    output logic [REG_ADDR_W-1:0] out_rd_addr,
    output logic [CTRL_W-1:0]     out_ctrl
);

    typedef struct packed {
        logic [DATA_W-1:0]     pc;
        logic [DATA_W-1:0]     rd1;
        logic [DATA_W-1:0]     rd2;
        logic [DATA_W-1:0]     imm;
        logic [REG_ADDR_W-1:0] rd_addr;
        logic [CTRL_W-1:0]     ctrl;
    } payload_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t   r_state;
    payload_t r_main;
    payload_t r_skid;
    logic     r_in_ready;
    logic     r_out_valid;

    payload_t w_in_pay;
    logic     w_in_fire;
    logic     w_out_fire;

    assign w_in_pay   = '{pc: in_pc, rd1: in_rd1, rd2: in_rd2, imm: in_imm,
                          rd_addr: in_rd_addr, ctrl: in_ctrl};
    assign w_in_fire  = in_valid & r_in_ready;
    assign w_out_fire = r_out_valid & out_ready;

    // Handshake flags are registered alongside the state so in_ready never
    // depends combinationally on out_ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_main      <= '0;
            r_skid      <= '0;
        end else if (flush) begin
            r_state     <= ST_EMPTY;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        r_main      <= w_in_pay;
                        r_state     <= ST_ONE;
                        r_out_valid <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        r_main <= w_in_pay;
                    end else if (w_in_fire) begin
                        r_skid     <= w_in_pay;
                        r_state    <= ST_FULL;
                        r_in_ready <= 1'b0;
                    end else if (w_out_fire) begin
                        r_state     <= ST_EMPTY;
                        r_out_valid <= 1'b0;
                    end
                end
                ST_FULL: begin
                    if (w_out_fire) begin
                        r_main     <= r_skid;
                        r_state    <= ST_ONE;
                        r_in_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= ST_EMPTY;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign out_pc      = r_main.pc;
    assign out_rd1     = r_main.rd1;
    assign out_rd2     = r_main.rd2;
    assign out_imm     = r_main.imm;
    assign out_rd_addr = r_main.rd_addr;
    // A bubble must look like a NOP to execute.
    assign out_ctrl    = r_out_valid ? r_main.ctrl : '0;

`ifdef IDEX_STATS_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall_cnt <= 32'd0;
        end else if (r_out_valid && !out_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// ============================================================================
// Module   : tb_id_ex_stage
// Brief    : Directed self-checking bench for id_ex_stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_id_ex_stage;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_rd1;
    logic [31:0] in_rd2;
    logic [31:0] in_imm;
    logic [3:0]  in_rd_addr;
    logic [7:0]  in_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_rd1;
    logic [31:0] out_rd2;
    logic [31:0] out_imm;
    logic [3:0]  out_rd_addr;
    logic [7:0]  out_ctrl;
`ifdef IDEX_STATS_EN
    logic [31:0] stall_cycles;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    id_ex_stage #(
        .DATA_W     (32),
        .REG_ADDR_W (4),
        .CTRL_W     (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_rd1       (in_rd1),
        .in_rd2       (in_rd2),
        .in_imm       (in_imm),
        .in_rd_addr   (in_rd_addr),
        .in_ctrl      (in_ctrl),
`ifdef IDEX_STATS_EN
        .stall_cycles (stall_cycles),
`endif
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_rd1      (out_rd1),
        .out_rd2      (out_rd2),
        .out_imm      (out_imm),
        .out_rd_addr  (out_rd_addr),
        .out_ctrl     (out_ctrl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] imm,
                         input logic [3:0] rda, input logic [7:0] ctrl);
        in_valid   = v;
        in_pc      = pc;
        in_rd1     = pc ^ 32'hA5A5_0000;
        in_rd2     = pc ^ 32'h0000_5A5A;
        in_imm     = imm;
        in_rd_addr = rda;
        in_ctrl    = ctrl;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 4'h0, 8'h0);

        // Reset
        cyc(); cyc();
        rst = 1'b0;
        cyc();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_ctrl", out_ctrl, 0);
        chk("rst_out_pc", out_pc, 0);
        chk("rst_out_rd1", out_rd1, 0);
        chk("rst_out_rd2", out_rd2, 0);
        chk("rst_out_imm", out_imm, 0);
        chk("rst_out_rd_addr", out_rd_addr, 0);
`ifdef IDEX_STATS_EN
        chk("rst_stall", stall_cycles, 0);
`endif

        // Streaming at full rate
        out_ready = 1'b1;
        drive(1'b1, 32'h100, 32'h1, 4'h1, 8'h11);
        cyc();
        chk("s0_valid", out_valid, 1);
        chk("s0_pc", out_pc, 32'h100);
        chk("s0_in_ready", in_ready, 1);
        drive(1'b1, 32'h104, 32'h2, 4'h2, 8'h12);
        cyc();
        chk("s1_pc", out_pc, 32'h104);
        chk("s1_ctrl", out_ctrl, 8'h12);
        chk("s1_rd1", out_rd1, 32'hA5A5_0104);
        chk("s1_in_ready", in_ready, 1);
        drive(1'b1, 32'h108, 32'h3, 4'h3, 8'h13);
        cyc();
        chk("s2_pc", out_pc, 32'h108);
        chk("s2_rd2", out_rd2, 32'h0000_5B52);
        chk("s2_in_ready", in_ready, 1);
        drive(1'b0, 32'h0, 32'h0, 4'h0, 8'h0);
        cyc();
        chk("s3_valid", out_valid, 0);
        chk("s3_ctrl_nop", out_ctrl, 0);
        chk("s3_pc_hold", out_pc, 32'h108);

        // Back-pressure fills the skid entry
        out_ready = 1'b0;
        drive(1'b1, 32'h200, 32'hFFFF_FF80, 4'h4, 8'h21);
        cyc();
        chk("bp_a_imm", out_imm, 32'hFFFF_FF80);
        chk("bp_a_in_ready", in_ready, 1);
        drive(1'b1, 32'h204, 32'h0000_007F, 4'h5, 8'h22);
        cyc();
        chk("bp_full_in_ready", in_ready, 0);
        chk("bp_full_imm", out_imm, 32'hFFFF_FF80);
        chk("bp_full_ctrl", out_ctrl, 8'h21);
        drive(1'b0, 32'h0, 32'h0, 4'h0, 8'h0);
        out_ready = 1'b1;
        cyc();
        chk("bp_b_valid", out_valid, 1);
        chk("bp_b_imm", out_imm, 32'h0000_007F);
        chk("bp_b_pc", out_pc, 32'h204);
        chk("bp_b_in_ready", in_ready, 1);
        cyc();
        chk("bp_empty_valid", out_valid, 0);
        chk("bp_empty_ctrl", out_ctrl, 0);

        // Flush while FULL with C offered
        out_ready = 1'b0;
        drive(1'b1, 32'h300, 32'h0, 4'h6, 8'h31);
        cyc();
        drive(1'b1, 32'h304, 32'h0, 4'h7, 8'h32);
        cyc();
        chk("fl_full_in_ready", in_ready, 0);
        drive(1'b1, 32'h308, 32'h0, 4'h8, 8'h33);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 4'h0, 8'h0);
        chk("fl_valid", out_valid, 0);
        chk("fl_in_ready", in_ready, 1);
        chk("fl_ctrl", out_ctrl, 0);
        out_ready = 1'b1;
        cyc();
        chk("fl_no_c_valid", out_valid, 0);
        chk("fl_no_c_ctrl", out_ctrl, 0);

        // Flush in ONE discards a same-cycle accepted bundle
        out_ready = 1'b0;
        drive(1'b1, 32'h400, 32'h0, 4'h9, 8'h41);
        cyc();
        chk("fl1_one_pc", out_pc, 32'h400);
        drive(1'b1, 32'h404, 32'h0, 4'hA, 8'h42);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 4'h0, 8'h0);
        chk("fl1_valid", out_valid, 0);
        chk("fl1_pc_not_loaded", out_pc, 32'h400);
        chk("fl1_in_ready", in_ready, 1);

        // Reset while holding one entry
        drive(1'b1, 32'h500, 32'h0, 4'h5, 8'h51);
        cyc();
        chk("mr_valid", out_valid, 1);
        chk("mr_rd_addr", out_rd_addr, 4'h5);
        drive(1'b0, 32'h0, 32'h0, 4'h0, 8'h0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mr_after_valid", out_valid, 0);
        chk("mr_after_in_ready", in_ready, 1);
        chk("mr_after_rd_addr", out_rd_addr, 0);
        out_ready = 1'b1;
        cyc();
        chk("mr_lost_valid", out_valid, 0);

`ifdef IDEX_STATS_EN
        // Stall counter
        out_ready = 1'b0;
        drive(1'b1, 32'h600, 32'h0, 4'h6, 8'h61);
        cyc();
        drive(1'b0, 32'h0, 32'h0, 4'h0, 8'h0);
        chk("st_start", stall_cycles, 0);
        for (int i = 0; i < 10; i++) cyc();
        chk("st_ten", stall_cycles, 10);
        out_ready = 1'b1;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("st_flush_keep", stall_cycles, 10);
        cyc();
        chk("st_idle_keep", stall_cycles, 10);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("st_rst_clear", stall_cycles, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
